i2s_stream_bridge: RTL

I2S_STREAM_BRIDGE -- requirements
Module: i2s_stream_bridge

---
 rtl/i2s_stream_bridge.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/i2s_stream_bridge.sv
// i2s_stream_bridge: bridges a parallel I2S transceiver to a pair of
// valid/ready stereo streams. Frames move on the falling edge of the word
// clock; RX frames are buffered towards the stream sink and TX frames are
// buffered from the stream source. Sticky flags record dropped/repeated frames.
module i2s_stream_bridge #(
    parameter int PDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   mclk_in,
    input  logic                   arstn_in,
    input  logic                   lrck_in,
    input  logic [PDATA_WIDTH-1:0] rx_pldata_in,
    input  logic [PDATA_WIDTH-1:0] rx_prdata_in,
    output logic                   m_valid_out,
    input  logic                   m_ready_in,
    output logic [PDATA_WIDTH-1:0] m_ldata_out,
    output logic [PDATA_WIDTH-1:0] m_rdata_out,
    input  logic                   s_valid_in,
    output logic                   s_ready_out,
    input  logic [PDATA_WIDTH-1:0] s_ldata_in,
    input  logic [PDATA_WIDTH-1:0] s_rdata_in,
    output logic [PDATA_WIDTH-1:0] tx_pldata_out,
    output logic [PDATA_WIDTH-1:0] tx_prdata_out,
    output logic                   frame_out,
    input  logic                   clr_flags_in,
    output logic                   rx_overrun_out,
    output logic                   tx_underrun_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int FW = 2 * PDATA_WIDTH;

    // Frame storage: left sample in the upper half, right sample in the lower half
    logic [FW-1:0]          rx_mem_q [FIFO_DEPTH];
    logic [FW-1:0]          tx_mem_q [FIFO_DEPTH];
    logic [PW-1:0]          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PW-1:0]          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic                   lrck_q;
    logic                   frame_q;
    logic                   ready_en_q;
    logic                   ovr_q, ovr_d;
    logic                   und_q, und_d;
    logic [PDATA_WIDTH-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;

    logic                   fe_s;
    logic                   rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
    logic                   rx_pop_s, rx_push_s, rx_drop_s;
    logic                   tx_push_s, tx_pop_s, tx_miss_s;
    logic [FW-1:0]          rx_head_s, tx_head_s;

    // Event decode: word-clock falling edge, FIFO status and handshakes
    always_comb begin
        fe_s       = lrck_q & ~lrck_in;
        rx_empty_s = (rx_wr_q == rx_rd_q);
        rx_full_s  = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
        tx_empty_s = (tx_wr_q == tx_rd_q);
        tx_full_s  = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
        rx_head_s  = rx_mem_q[rx_rd_q[AW-1:0]];
        tx_head_s  = tx_mem_q[tx_rd_q[AW-1:0]];
        rx_pop_s   = ~rx_empty_s & m_ready_in;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        rx_push_s  = fe_s & (~rx_full_s | rx_pop_s);
        rx_drop_s  = fe_s & rx_full_s & ~rx_pop_s;
        tx_push_s  = s_valid_in & ready_en_q & ~tx_full_s;
        tx_pop_s   = fe_s & ~tx_empty_s;
        tx_miss_s  = fe_s & tx_empty_s;
    end

    // Next-state for pointers, TX output holding registers and sticky flags
    always_comb begin
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;
        tx_wr_d = tx_wr_q;
        tx_rd_d = tx_rd_q;
        tx_l_d  = tx_l_q;
        tx_r_d  = tx_r_q;
        if (rx_push_s) begin
            rx_wr_d = rx_wr_q + PW'(1);
        end else begin
            rx_wr_d = rx_wr_q;
        end
        if (rx_pop_s) begin
            rx_rd_d = rx_rd_q + PW'(1);
        end else begin
            rx_rd_d = rx_rd_q;
        end
        if (tx_push_s) begin
            tx_wr_d = tx_wr_q + PW'(1);
        end else begin
            tx_wr_d = tx_wr_q;
        end
        // The TX outputs only ever change on a frame event; an empty FIFO holds them
        if (tx_pop_s) begin
            tx_rd_d = tx_rd_q + PW'(1);
            tx_l_d  = tx_head_s[FW-1:PDATA_WIDTH];
            tx_r_d  = tx_head_s[PDATA_WIDTH-1:0];
        end else begin
            tx_rd_d = tx_rd_q;
            tx_l_d  = tx_l_q;
            tx_r_d  = tx_r_q;
        end
        // A fresh event outranks a clear in the same cycle
        ovr_d = (ovr_q & ~clr_flags_in) | rx_drop_s;
        und_d = (und_q & ~clr_flags_in) | tx_miss_s;
    end

    // Control and status registers
    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            lrck_q     <= 1'b0;
            frame_q    <= 1'b0;
            ready_en_q <= 1'b0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            ovr_q      <= 1'b0;
            und_q      <= 1'b0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
        end else begin
            lrck_q     <= lrck_in;
            frame_q    <= fe_s;
            ready_en_q <= 1'b1;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
        end
    end

    // Frame storage writes; cleared on reset so no stale frame survives
    always_ff @(posedge mclk_in or negedge arstn_in) begin
        if (!arstn_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_q[i] <= '0;
                tx_mem_q[i] <= '0;
            end
        end else begin
            if (rx_push_s) begin
                rx_mem_q[rx_wr_q[AW-1:0]] <= {rx_pldata_in, rx_prdata_in};
            end
            if (tx_push_s) begin
                tx_mem_q[tx_wr_q[AW-1:0]] <= {s_ldata_in, s_rdata_in};
            end
        end
    end

    assign m_valid_out     = ~rx_empty_s;
    assign m_ldata_out     = rx_empty_s ? '0 : rx_head_s[FW-1:PDATA_WIDTH];
    assign m_rdata_out     = rx_empty_s ? '0 : rx_head_s[PDATA_WIDTH-1:0];
    assign s_ready_out     = ready_en_q & ~tx_full_s;
    assign tx_pldata_out   = tx_l_q;
    assign tx_prdata_out   = tx_r_q;
    assign frame_out       = frame_q;
    assign rx_overrun_out  = ovr_q;
    assign tx_underrun_out = und_q;

endmodule
